// File: rtl/sha256_round_ctrl_if.sv
// Signal bundle between the SHA-256 round sequencer and its surroundings:
// message stream, K ROM lookup, shared hash-function unit and digest/status.
interface sha256_round_ctrl_if;
    logic         start;
    logic         init;
    logic [31:0]  msg_word;
    logic         msg_valid;
    logic         msg_ready;
    logic [5:0]   k_idx;
    logic [31:0]  k_word;
    logic [2:0]   hfnc_op;
    logic [31:0]  hfnc_x;
    logic [31:0]  hfnc_y;
    logic [31:0]  hfnc_z;
    logic [31:0]  hfnc_res;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    // The sequencer owns the stream ready, ROM index, function-unit operands and status.
    modport master (
        input  start, init, msg_word, msg_valid, k_word, hfnc_res,
        output msg_ready, k_idx, hfnc_op, hfnc_x, hfnc_y, hfnc_z, busy, done, digest
    );

    modport slave (
        output start, init, msg_word, msg_valid, k_word, hfnc_res,
        input  msg_ready, k_idx, hfnc_op, hfnc_x, hfnc_y, hfnc_z, busy, done, digest
    );
endinterface

// File: rtl/sha256_round_ctrl.sv
// One SHA-256 compression (64 rounds) sequenced over a single shared
// hash-function unit; holds working variables, 16-word schedule and H0..H7.
module sha256_round_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_round_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        IDLE, WGET, WS0, WS1, RS1, RCH, RS0, RMAJ, FINAL
    } stateT;

    typedef enum logic [2:0] {
        OP_CH    = 3'd0,
        OP_MAJ   = 3'd1,
        OP_BSIG0 = 3'd4,
        OP_BSIG1 = 3'd5,
        OP_SSIG0 = 3'd6,
        OP_SSIG1 = 3'd7
    } hfncOpT;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    stateT       state;
    stateT       nextState;

    logic [31:0] hReg [8];
    logic [31:0] work [8];
    logic [31:0] wbuf [16];
    logic [5:0]  t;
    logic [31:0] acc;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] wt;
    logic        initReg;
    logic        doneReg;

    logic [3:0]  idx;
    logic [3:0]  idxM15;
    logic [3:0]  idxM7;
    logic [3:0]  idxM2;
    logic [6:0]  tInc;
    logic [31:0] res;
    logic [31:0] wtNew;

    assign res    = bus.hfnc_res;
    assign idx    = t[3:0];
    assign idxM15 = idx + 4'd1;
    assign idxM7  = idx + 4'd9;
    assign idxM2  = idx - 4'd2;
    assign tInc   = {1'b0, t} + 7'd1;
    assign wtNew  = acc + res + wbuf[idxM7] + wbuf[idx];

    assign bus.msg_ready = (state == WGET);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = doneReg;
    assign bus.k_idx     = t;
    assign bus.digest    = {hReg[0], hReg[1], hReg[2], hReg[3],
                            hReg[4], hReg[5], hReg[6], hReg[7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path through it leaves a signal unassigned and infers a latch.
        nextState  = state;
        bus.hfnc_op = OP_CH;
        bus.hfnc_x  = '0;
        bus.hfnc_y  = '0;
        bus.hfnc_z  = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nextState = WGET;
                end
            end
            WGET: begin
                if (bus.msg_valid) begin
                    nextState = RS1;
                end
            end
            WS0: begin
                bus.hfnc_op = OP_SSIG0;
                bus.hfnc_x  = wbuf[idxM15];
                nextState   = WS1;
            end
            WS1: begin
                bus.hfnc_op = OP_SSIG1;
                bus.hfnc_x  = wbuf[idxM2];
                nextState   = RS1;
            end
            RS1: begin
                bus.hfnc_op = OP_BSIG1;
                bus.hfnc_x  = work[4];
                nextState   = RCH;
            end
            RCH: begin
                bus.hfnc_op = OP_CH;
                bus.hfnc_x  = work[4];
                bus.hfnc_y  = work[5];
                bus.hfnc_z  = work[6];
                nextState   = RS0;
            end
            RS0: begin
                bus.hfnc_op = OP_BSIG0;
                bus.hfnc_x  = work[0];
                nextState   = RMAJ;
            end
            RMAJ: begin
                bus.hfnc_op = OP_MAJ;
                bus.hfnc_x  = work[0];
                bus.hfnc_y  = work[1];
                bus.hfnc_z  = work[2];
                if (tInc < 7'd16) begin
                    nextState = WGET;
                end else if (tInc < 7'd64) begin
                    nextState = WS0;
                end else begin
                    nextState = FINAL;
                end
            end
            FINAL: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the schedule buffer is only 16 words and must read back as
            // zero after reset, so it is reset like ordinary flops, not left as RAM.
            for (int i = 0; i < 8; i++) begin
                hReg[i] <= '0;
                work[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                wbuf[i] <= '0;
            end
            t       <= '0;
            acc     <= '0;
            t1      <= '0;
            t2      <= '0;
            wt      <= '0;
            initReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= (state == FINAL);
            case (state)
                IDLE: begin
                    // The digest keeps showing the last result during a block;
                    // an IV start is remembered and applied as the base in FINAL.
                    if (bus.start) begin
                        initReg <= bus.init;
                        t       <= '0;
                        for (int i = 0; i < 8; i++) begin
                            work[i] <= bus.init ? SHA256_IV[255-32*i -: 32] : hReg[i];
                        end
                    end
                end
                WGET: begin
                    if (bus.msg_valid) begin
                        wbuf[idx] <= bus.msg_word;
                        wt        <= bus.msg_word;
                    end
                end
                WS0: begin
                    acc <= res;
                end
                WS1: begin
                    wt        <= wtNew;
                    wbuf[idx] <= wtNew;
                end
                RS1: begin
                    t1 <= work[7] + res + bus.k_word + wt;
                end
                RCH: begin
                    t1 <= t1 + res;
                end
                RS0: begin
                    t2 <= res;
                end
                RMAJ: begin
                    // NOTE: non-blocking assignments let the whole a..h shift
                    // read the pre-edge values, exactly like the round equations.
                    work[0] <= t1 + t2 + res;
                    work[1] <= work[0];
                    work[2] <= work[1];
                    work[3] <= work[2];
                    work[4] <= work[3] + t1;
                    work[5] <= work[4];
                    work[6] <= work[5];
                    work[7] <= work[6];
                    t       <= tInc[5:0];
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        hReg[i] <= (initReg ? SHA256_IV[255-32*i -: 32] : hReg[i]) + work[i];
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: models the K ROM and hash-function
// unit, and checks digests against a plain SHA-256 compression reference.
module tb_sha256_round_ctrl;
    logic clk;
    logic rst_n;

    sha256_round_ctrl_if bus ();

    sha256_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    typedef struct {
        logic         ini;
        logic         b2b;
        logic         hasExp;
        logic [511:0] blk;
        logic [255:0] expD;
    } vecT;

    int           checks = 0;
    int           errors = 0;
    logic [255:0] curH;
    logic [511:0] abcBlk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] fCh(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction
    function automatic logic [31:0] fMaj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction
    function automatic logic [31:0] bSig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction
    function automatic logic [31:0] bSig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction
    function automatic logic [31:0] sSig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sSig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // External K ROM and shared hash-function unit, both combinational.
    always_comb begin
        bus.k_word   = K_ROM[bus.k_idx];
        bus.hfnc_res = '0;
        case (bus.hfnc_op)
            3'd0:    bus.hfnc_res = fCh(bus.hfnc_x, bus.hfnc_y, bus.hfnc_z);
            3'd1:    bus.hfnc_res = fMaj(bus.hfnc_x, bus.hfnc_y, bus.hfnc_z);
            3'd4:    bus.hfnc_res = bSig0(bus.hfnc_x);
            3'd5:    bus.hfnc_res = bSig1(bus.hfnc_x);
            3'd6:    bus.hfnc_res = sSig0(bus.hfnc_x);
            3'd7:    bus.hfnc_res = sSig1(bus.hfnc_x);
            default: bus.hfnc_res = '0;
        endcase
    end

    // Textbook compression: full 64-word schedule, then 64 rounds.
    function automatic logic [255:0] refCompress(input logic [255:0] hIn, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  x1;
        logic [31:0]  x2;
        logic [255:0] out;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) w[i] = sSig1(w[i-2]) + w[i-7] + sSig0(w[i-15]) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = hIn[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            x1 = v[7] + bSig1(v[4]) + fCh(v[4], v[5], v[6]) + K_ROM[i] + w[i];
            x2 = bSig0(v[0]) + fMaj(v[0], v[1], v[2]);
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) out[255-32*i -: 32] = hIn[255-32*i -: 32] + v[i];
        return out;
    endfunction

    // Round in progress during the cycle after edge e of a stall-free block.
    function automatic int expRound(input int e);
        return (e < 80) ? e / 5 : 16 + (e - 80) / 6;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkZeroOutputs(input string tag);
        check({tag, "_msg_ready"}, 256'(bus.msg_ready), '0);
        check({tag, "_busy"},      256'(bus.busy),      '0);
        check({tag, "_done"},      256'(bus.done),      '0);
        check({tag, "_k_idx"},     256'(bus.k_idx),     '0);
        check({tag, "_hfnc_op"},   256'(bus.hfnc_op),   '0);
        check({tag, "_hfnc_xyz"},  256'({bus.hfnc_x, bus.hfnc_y, bus.hfnc_z}), '0);
        check({tag, "_digest"},    bus.digest,          '0);
    endtask

    // Runs one block starting at a negedge; returns at the negedge of the done cycle.
    task automatic runBlock(input logic ini, input logic [511:0] blk, input int maxGap,
                            input int pulseA, input int pulseB, input int abortAt,
                            output int latency, output bit gotDone);
        int           edgeCnt;
        int           wordIdx;
        int           gap;
        int           stalls;
        int           extraReady;
        logic [255:0] expD;
        latency    = -1;
        gotDone    = 1'b0;
        stalls     = 0;
        extraReady = 0;
        wordIdx    = 0;
        expD       = refCompress(ini ? IV : curH, blk);
        gap        = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
        bus.start     = 1'b1;
        bus.init      = ini;
        bus.msg_valid = 1'b0;
        @(posedge clk);
        edgeCnt = 0;
        for (int iter = 0; iter < 2000; iter++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.init  = 1'b0;
            if (edgeCnt == pulseA || edgeCnt == pulseB) begin
                bus.start = 1'b1;
                bus.init  = 1'b1;
            end
            if (edgeCnt == abortAt) begin
                rst_n         = 1'b0;
                bus.msg_valid = 1'b0;
                #1;
                checkZeroOutputs("abort");
                curH = '0;
                return;
            end
            if (bus.done) begin
                latency = edgeCnt;
                gotDone = 1'b1;
                break;
            end
            if (edgeCnt == 0) check("wget_ops_zero", 256'({bus.hfnc_op, bus.hfnc_x, bus.hfnc_y, bus.hfnc_z}), '0);
            if (edgeCnt == 1) check("busy_running", 256'(bus.busy), 256'(1));
            if (edgeCnt == 100) check("digest_holds", bus.digest, curH);
            if (maxGap == 0 && edgeCnt % 23 == 7 && edgeCnt < 368)
                check("k_idx_round", 256'(bus.k_idx), 256'(expRound(edgeCnt)));
            if (maxGap == 0 && edgeCnt == 368)
                check("final_ops_zero", 256'({bus.hfnc_op, bus.hfnc_x, bus.hfnc_y, bus.hfnc_z}), '0);
            if (wordIdx < 16) begin
                if (gap > 0) begin
                    bus.msg_valid = 1'b0;
                    gap--;
                end else begin
                    bus.msg_valid = 1'b1;
                    bus.msg_word  = blk[511-32*wordIdx -: 32];
                end
            end else begin
                bus.msg_valid = 1'b1;
                bus.msg_word  = 32'hdeadbeef;
            end
            if (bus.msg_ready) begin
                if (!bus.msg_valid) begin
                    stalls++;
                end else if (wordIdx >= 16) begin
                    extraReady++;
                end else begin
                    wordIdx++;
                    gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
                end
            end
            @(posedge clk);
            edgeCnt++;
        end
        bus.msg_valid = 1'b0;
        bus.start     = 1'b0;
        check("done_seen", 256'(gotDone), 256'(1));
        if (gotDone) begin
            check("latency", 256'(latency), 256'(369 + stalls));
            check("digest_model", bus.digest, expD);
            check("words_taken", 256'(wordIdx), 256'(16));
            check("ready_outside_wget", 256'(extraReady), '0);
        end
        curH = expD;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        vecT          vecs [4];
        int           lat;
        bit           ok;
        logic         ini;
        logic [511:0] blk;

        abcBlk = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        vecs[0] = '{ini: 1'b1, b2b: 1'b0, hasExp: 1'b1, blk: abcBlk, expD: ABC_DIGEST};
        vecs[1] = '{ini: 1'b1, b2b: 1'b0, hasExp: 1'b1,
                    blk: {32'h80000000, {15{32'h00000000}}},
                    expD: 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
        vecs[2] = '{ini: 1'b1, b2b: 1'b0, hasExp: 1'b0,
                    blk: {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000},
                    expD: '0};
        vecs[3] = '{ini: 1'b0, b2b: 1'b1, hasExp: 1'b1,
                    blk: {{15{32'h00000000}}, 32'h000001c0},
                    expD: 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.init      = 1'b0;
        bus.msg_valid = 1'b0;
        bus.msg_word  = '0;
        curH          = '0;
        repeat (3) @(negedge clk);
        checkZeroOutputs("reset");
        rst_n = 1'b1;

        // Known-answer vectors; the chained second block starts in the done cycle.
        for (int i = 0; i < 4; i++) begin
            if (!vecs[i].b2b) repeat (2) @(negedge clk);
            runBlock(vecs[i].ini, vecs[i].blk, 0, -1, -1, -1, lat, ok);
            if (vecs[i].hasExp) check("vec_digest", bus.digest, vecs[i].expD);
        end
        @(negedge clk);
        check("done_one_cycle", 256'(bus.done), '0);
        check("idle_not_busy", 256'(bus.busy), '0);

        // "abc" with random 0-7 cycle gaps before each word.
        repeat (2) @(negedge clk);
        runBlock(1'b1, abcBlk, 7, -1, -1, -1, lat, ok);
        check("gap_digest", bus.digest, ABC_DIGEST);

        // Stray start pulses during rounds 5 and 40.
        repeat (3) @(negedge clk);
        runBlock(1'b1, abcBlk, 0, 27, 226, -1, lat, ok);
        check("pulse_digest", bus.digest, ABC_DIGEST);

        // Random blocks, mixing IV starts, chaining, stalls and back-to-back starts.
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 16; j++) blk[511-32*j -: 32] = $urandom();
            ini = (r == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            if (r != 2) repeat (1 + r) @(negedge clk);
            runBlock(ini, blk, (r % 2 == 1) ? 3 : 0, -1, -1, -1, lat, ok);
        end

        // Reset during round 30, then a clean "abc" run.
        repeat (2) @(negedge clk);
        runBlock(1'b1, abcBlk, 0, -1, -1, 166, lat, ok);
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_reset", 256'(bus.done), '0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        runBlock(1'b1, abcBlk, 0, -1, -1, -1, lat, ok);
        check("after_reset_digest", bus.digest, ABC_DIGEST);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencer that computes one SHA-256 compression, a 64-round block update, by time-multiplexing a single shared hash-function unit. That unit implements Ch, Maj, Σ0, Σ1, σ0 and σ1 and is selected by a 3-bit opcode. The block accepts 16 message words over a valid/ready stream and holds the working variables, the 16-word circular message schedule and the chaining state H0..H7. It fetches round constants from an external K ROM and presents the 256-bit digest when done. It sits between the message/padding front end and the digest readout.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin one block; sampled only in IDLE.
- `init`  in  1  sampled with `start`:
  - 1: load H0..H7 with the SHA-256 IV.
  - 0: chain from the current digest.
- `msg_word`  in  32  message word W[t], t = 0..15, big-endian word order.
- `msg_valid`  in  1  `msg_word` valid.
- `msg_ready`  out  1  high in WGET; a word transfers when `msg_valid` and `msg_ready` are both high.
- `k_idx`  out  6  current round t.
- `k_word`  in  32  K[`k_idx`], combinational from the ROM.
- `hfnc_op`  out  3  opcode to the function unit: 0 Ch, 1 Maj, 4 Σ0, 5 Σ1, 6 σ0, 7 σ1.
- `hfnc_x`, `hfnc_y`, `hfnc_z`  out  32 each  operands to the function unit.
- `hfnc_res`  in  32  result from the function unit, combinational.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; the digest is valid.
- `digest`  out  256  {H0..H7}, with H0 in bits 255:224.

## Operation
- All additions are mod 2^32; carries are discarded.
- The schedule buffer is `wbuf[0:15]`, indexed by t mod 16.
- States: IDLE, WGET, WS0, WS1, RS1, RCH, RS0, RMAJ, FINAL.
- IDLE: when `start` is high, load H (IV if `init`, otherwise keep), load a..h ← H, set t ← 0, go to WGET if t < 16.
- WGET (t < 16): wait for the handshake. On transfer, `wbuf[t]` ← `msg_word` and Wt ← `msg_word`, then go to RS1. The state holds indefinitely while `msg_valid` is low.
- WS0 (t ≥ 16): op 6, x = `wbuf[(t-15)%16]`; acc ← `hfnc_res`.
- WS1: op 7, x = `wbuf[(t-2)%16]`.
  - Wt ← acc + `hfnc_res` + `wbuf[(t-7)%16]` + `wbuf[t%16]`.
  - `wbuf[t%16]` ← Wt; the old value is W[t-16], read in the same cycle.
- RS1: op 5, x = e; t1 ← h + `hfnc_res` + `k_word` + Wt.
- RCH: op 0, x/y/z = e/f/g; t1 ← t1 + `hfnc_res`.
- RS0: op 4, x = a; t2 ← `hfnc_res`.
- RMAJ: op 1, x/y/z = a/b/c. Apply the round update:
  - a ← t1 + t2 + `hfnc_res`
  - e ← d + t1
  - b ← a, c ← b, d ← c, f ← e, g ← f, h ← g
  - t ← t+1
  - next state: WGET if t+1 < 16, WS0 if t+1 < 64, FINAL otherwise.
- FINAL: Hi ← Hi + working variable i for i = 0..7; go to IDLE and pulse `done`.
- Outside the op states, `hfnc_op` = 0 and `hfnc_x/y/z` = 0. Unused operands are 0.
- `start` while busy is ignored.
- `msg_valid` while not in WGET is ignored; no word is consumed.

## Timing
- Reset values:
  - `digest`, a..h, `wbuf`, t, acc, t1, t2 = 0.
  - state = IDLE.
  - `msg_ready`, `busy`, `done`, `k_idx`, `hfnc_op`, `hfnc_x/y/z` = 0.
- Reset asserted mid-block aborts immediately. The partial digest is discarded and all values return to reset; no `done` is issued.
- Round cost:
  - t < 16: 5 cycles (WGET, RS1, RCH, RS0, RMAJ), plus any stall cycles in WGET.
  - t ≥ 16: 6 cycles.
- Latency with no stalls: the `start` edge is edge 0. FINAL completes at edge 369, and `done` is high in the following cycle (80 + 288 + 1 clocks).
- `digest` updates at the same edge that raises `done`. It then holds until the next FINAL or reset.
- `k_idx` equals t and is stable for the whole round. `k_word` is sampled only in RS1.
- `start` is accepted in the cycle in which `done` is high; back-to-back blocks are allowed.

## Test plan
- Reset, then "abc": `init`=1, words 0x61626380, fourteen 0x00000000, 0x00000018, `msg_valid` held high.
  - Required: `done` 369 cycles after `start`.
  - Required: `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: words 0x80000000 then fifteen zeros.
  - Required: `digest` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block chain "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with `init`=1, block 2 with `init`=0, `start` raised in the `done` cycle.
  - Required: `digest` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- "abc" with random `msg_valid` gaps (0-7 cycles per word).
  - Required: same digest; `done` latency = 369 + total stall cycles; `msg_ready` low outside WGET.
- `start` pulsed at rounds 5 and 40 while busy.
  - Required: ignored; the "abc" digest is unchanged.
- `rst_n` low at round 30.
  - Required: all outputs 0 immediately; no `done`.
  - Required: a subsequent "abc" run gives the correct digest.
